// File: rtl/vmx_mm_stream_ctrl_pkg.sv
// Shared definitions for the matrix-vector streaming controller.
//   state_t        : controller FSM encoding, also reported in status[2:0]
//   LC_*           : field layout of one per-lane pe_load_ctrl byte
//   STAT_*         : bit positions inside the 32-bit status word
//   lc_byte()      : packs a load-control byte from its fields
package vmx_mm_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GETW  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam int LC_W      = 8;
  localparam int LC_EN_BIT = 7;
  localparam int LC_ROW_W  = 7;

  localparam int STAT_ERR_BIT   = 7;
  localparam int STAT_ABORT_BIT = 6;
  localparam int STAT_BUSY_BIT  = 5;
  localparam int STAT_STATE_W   = 3;

  function automatic logic [LC_W-1:0] lc_byte(input logic en, input logic [LC_ROW_W-1:0] row);
    logic [LC_W-1:0] b;
    b = '0;
    b[LC_EN_BIT] = en;
    b[LC_ROW_W-1:0] = row;
    return b;
  endfunction

endpackage

// File: rtl/vmx_mm_stream_ctrl_skew_line.sv
// Per-lane register delay line of DEPTH stages (DEPTH >= 1).
//   clk, rst_n : clock, async active-low reset (clears all stages)
//   clr        : synchronous flush of all stages
//   din, dout  : W-bit lane in / lane delayed by DEPTH cycles
module vmx_mm_stream_ctrl_skew_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if (clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vmx_mm_stream_ctrl.sv
// Matrix-vector streaming controller: loads PE_SIZE weight rows from BRAM
// into the PE array, streams nvec input vectors through it and writes each
// deskewed product vector back to BRAM.
//   start/abort/simd_mode/rbase_addr/wbase_addr/nvec : job control inputs
//   mem_addr/mem_rd_en/mem_wr_en/mem_rdata/mem_wdata : single-port BRAM side
//   pe_rst_n/pe_simd/pe_load_ctrl/pe_vector/pe_product : PE array side
//   busy/done/status : job status towards the control registers
module vmx_mm_stream_ctrl
  import vmx_mm_stream_ctrl_pkg::*;
#(
  parameter int PE_SIZE    = 4,
  parameter int PORT_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int NVEC_WIDTH = 8,
  parameter int PE_LAT     = 4,
  parameter int OUT_STRIDE = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              simd_mode,
  input  logic [ADDR_WIDTH-1:0]             rbase_addr,
  input  logic [ADDR_WIDTH-1:0]             wbase_addr,
  input  logic [NVEC_WIDTH-1:0]             nvec,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_rd_en,
  output logic                              mem_wr_en,
  input  logic [PORT_WIDTH*PE_SIZE-1:0]     mem_rdata,
  output logic [2*PORT_WIDTH*PE_SIZE-1:0]   mem_wdata,
  output logic                              pe_rst_n,
  output logic                              pe_simd,
  output logic [LC_W*PE_SIZE-1:0]           pe_load_ctrl,
  output logic [PORT_WIDTH*PE_SIZE-1:0]     pe_vector,
  input  logic [2*PORT_WIDTH*PE_SIZE-1:0]   pe_product,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       status
);

  // Read cycle of vector j to its write cycle: BRAM + input skew + PE + deskew.
  localparam int LAT = PE_SIZE + PE_LAT;
  localparam int CW  = NVEC_WIDTH + 1;
  localparam int IW  = PORT_WIDTH;
  localparam int OW  = 2 * PORT_WIDTH;

  state_t                  state, state_nx;
  logic [CW-1:0]           rcnt, wcnt;
  logic [NVEC_WIDTH-1:0]   nvec_q;
  logic [ADDR_WIDTH-1:0]   rbase_q, wbase_q;
  logic                    simd_q, err_sticky, abort_seen, abort_q;
  logic                    rd, wr_vld, accept, tok_in;
  logic                    rd_vld_p1;
  logic [IW*PE_SIZE-1:0]   rdata_p1;
  logic [OW*PE_SIZE-1:0]   prod_dsk;
  logic [LC_W-1:0]         lc_p0;

  assign accept = (state == ST_IDLE) && start && !abort && (nvec != '0);
  // A write cycle owns the BRAM port, so LOAD reads stall while a token exits.
  assign rd     = (state == ST_GETW) || ((state == ST_LOAD) && !wr_vld);
  assign tok_in = rd && (state == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nx = ST_GETW;
        ST_GETW:  if (rcnt == CW'(PE_SIZE - 1)) state_nx = ST_LOAD;
        ST_LOAD:  if (rd && ((rcnt + CW'(1)) == {1'b0, nvec_q})) state_nx = ST_DRAIN;
        // Counting the write in flight lets FIN follow the last write directly.
        ST_DRAIN: if ((wcnt + CW'(wr_vld)) == {1'b0, nvec_q}) state_nx = ST_FIN;
        ST_FIN:   state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd_en = rd;
    mem_wr_en = wr_vld;
    mem_addr  = '0;
    if (wr_vld)
      mem_addr = wbase_q + ADDR_WIDTH'(wcnt) * ADDR_WIDTH'(OUT_STRIDE);
    else if (state == ST_GETW)
      mem_addr = rbase_q + ADDR_WIDTH'(rcnt);
    else if (tok_in)
      mem_addr = rbase_q + ADDR_WIDTH'(PE_SIZE) + ADDR_WIDTH'(rcnt);
    busy = (state != ST_IDLE);
    done = (state == ST_FIN) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt       <= '0;
      wcnt       <= '0;
      nvec_q     <= '0;
      rbase_q    <= '0;
      wbase_q    <= '0;
      simd_q     <= 1'b0;
      err_sticky <= 1'b0;
      abort_seen <= 1'b0;
      abort_q    <= 1'b0;
      rd_vld_p1  <= 1'b0;
    end else begin
      abort_q   <= abort;
      rd_vld_p1 <= rd && !abort;

      // Counters are cleared on abort so a start in the very next cycle is clean.
      if (abort || state == ST_IDLE)     rcnt <= '0;
      else if (state == ST_GETW)         rcnt <= (rcnt == CW'(PE_SIZE - 1)) ? '0 : rcnt + CW'(1);
      else if (tok_in)                   rcnt <= rcnt + CW'(1);

      if (abort || state == ST_IDLE)     wcnt <= '0;
      else if (wr_vld)                   wcnt <= wcnt + CW'(1);

      if (accept) begin
        nvec_q  <= nvec;
        rbase_q <= rbase_addr;
        wbase_q <= wbase_addr;
        simd_q  <= simd_mode;
      end

      if (accept)
        err_sticky <= 1'b0;
      else if (state == ST_IDLE && start && !abort)
        err_sticky <= 1'b1;

      if (abort)       abort_seen <= 1'b1;
      else if (accept) abort_seen <= 1'b0;
    end
  end

  assign pe_rst_n = rst_n & ~abort_q;
  assign pe_simd  = simd_q;

  always_comb begin
    status = '0;
    status[STAT_ERR_BIT]       = err_sticky;
    status[STAT_ABORT_BIT]     = abort_seen;
    status[STAT_BUSY_BIT]      = busy;
    status[STAT_STATE_W-1:0]   = state;
  end

  // ---- stage p0 -> p1: BRAM read data (valid one cycle after the strobe)
  assign rdata_p1 = rd_vld_p1 ? mem_rdata : '0;
  assign lc_p0    = lc_byte(state == ST_GETW, LC_ROW_W'(rcnt));

  // ---- lanes: input skew k, load-control skew k+1, output deskew PE_SIZE-1-k
  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    if (k == 0) begin : g_in_direct
      assign pe_vector[0 +: IW] = rdata_p1[0 +: IW];
    end else begin : g_in_skew
      vmx_mm_stream_ctrl_skew_line #(.W(IW), .DEPTH(k)) u_in (
        .clk(clk), .rst_n(rst_n), .clr(abort),
        .din(rdata_p1[k*IW +: IW]), .dout(pe_vector[k*IW +: IW]));
    end

    vmx_mm_stream_ctrl_skew_line #(.W(LC_W), .DEPTH(k + 1)) u_lc (
      .clk(clk), .rst_n(rst_n), .clr(abort),
      .din(lc_p0), .dout(pe_load_ctrl[k*LC_W +: LC_W]));

    if (k == PE_SIZE - 1) begin : g_out_direct
      assign prod_dsk[k*OW +: OW] = pe_product[k*OW +: OW];
    end else begin : g_out_deskew
      vmx_mm_stream_ctrl_skew_line #(.W(OW), .DEPTH(PE_SIZE - 1 - k)) u_out (
        .clk(clk), .rst_n(rst_n), .clr(abort),
        .din(pe_product[k*OW +: OW]), .dout(prod_dsk[k*OW +: OW]));
    end
  end

  // ---- valid tracker: one token per vector read, exits on its write cycle
  vmx_mm_stream_ctrl_skew_line #(.W(1), .DEPTH(LAT)) u_vld (
    .clk(clk), .rst_n(rst_n), .clr(abort),
    .din(tok_in), .dout(wr_vld));

  assign mem_wdata = wr_vld ? prod_dsk : '0;

endmodule

// File: tb/tb_vmx_mm_stream_ctrl.sv
module tb_vmx_mm_stream_ctrl;
  localparam int PE_SIZE = 4, PORT_WIDTH = 16, ADDR_WIDTH = 8;
  localparam int NVEC_WIDTH = 8, PE_LAT = 4, OUT_STRIDE = 2;

  logic clk = 1'b0;
  logic rst_n, start, abort, simd_mode;
  logic [7:0] rbase_addr, wbase_addr, nvec, mem_addr;
  logic mem_rd_en, mem_wr_en, pe_rst_n, pe_simd, busy, done;
  logic [63:0] mem_rdata = '0;
  logic [127:0] mem_wdata, pe_product;
  logic [31:0] pe_load_ctrl, status;
  logic [63:0] pe_vector;

  vmx_mm_stream_ctrl #(.PE_SIZE(PE_SIZE), .PORT_WIDTH(PORT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NVEC_WIDTH(NVEC_WIDTH), .PE_LAT(PE_LAT), .OUT_STRIDE(OUT_STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .simd_mode(simd_mode),
    .rbase_addr(rbase_addr), .wbase_addr(wbase_addr), .nvec(nvec),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .pe_rst_n(pe_rst_n),
    .pe_simd(pe_simd), .pe_load_ctrl(pe_load_ctrl), .pe_vector(pe_vector),
    .pe_product(pe_product), .busy(busy), .done(done), .status(status));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read
  logic [63:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // PE array stand-in: lane-local weight (row i, lane i) times input, PE_LAT deep
  logic [15:0] wdiag [4];
  logic [31:0] ppipe [4][4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!pe_rst_n) begin
        wdiag[i] <= '0;
        for (int s = 0; s < 4; s++) ppipe[s][i] <= '0;
      end else begin
        if (pe_load_ctrl[8*i+7] && pe_load_ctrl[8*i +: 7] == 7'(i)) wdiag[i] <= pe_vector[16*i +: 16];
        ppipe[0][i] <= 32'(pe_vector[16*i +: 16]) * 32'(wdiag[i]);
        for (int s = 1; s < 4; s++) ppipe[s][i] <= ppipe[s-1][i];
      end
    end
  end
  always_comb begin
    pe_product = '0;
    for (int i = 0; i < 4; i++) pe_product[32*i +: 32] = ppipe[3][i];
  end

  typedef struct { logic [7:0] addr; logic [127:0] data; } exp_t;
  exp_t sb_q[$];
  exp_t e_m;
  logic [7:0] rd_addr_q[$];
  int rd_rel_q[$], wr_rel_q[$];
  int wr_cnt, done_cnt, done_rel, pe_rst_lo, rel_m;

  // Monitor: every write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (rst_n) begin
      rel_m = cyc - t0;
      if (mem_rd_en) begin rd_addr_q.push_back(mem_addr); rd_rel_q.push_back(rel_m); end
      if (mem_wr_en) begin
        wr_cnt++;
        wr_rel_q.push_back(rel_m);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got write addr %h data %h, required no write", mem_addr, mem_wdata);
        end else begin
          e_m = sb_q.pop_front();
          if (mem_addr !== e_m.addr || mem_wdata !== e_m.data || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_data: got addr %h data %h rd_en %b, required addr %h data %h rd_en 0",
                     mem_addr, mem_wdata, mem_rd_en, e_m.addr, e_m.data);
          end
        end
      end
      if (done) begin done_cnt++; done_rel = rel_m; end
      if (!pe_rst_n) pe_rst_lo++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill_job(input logic [7:0] rb, input int nv, input bit ident);
    logic [63:0] row;
    for (int i = 0; i < 4; i++) begin
      row = '0;
      row[16*i +: 16] = ident ? 16'd1 : 16'(i + 2);
      mem[rb + 8'(i)] = row;
    end
    for (int j = 0; j < nv; j++) mem[rb + 8'(4 + j)] = {$urandom(), $urandom()};
  endtask

  task automatic push_job(input logic [7:0] rb, input logic [7:0] wb, input int nv);
    exp_t e;
    logic [63:0] v, w;
    for (int j = 0; j < nv; j++) begin
      e.addr = wb + 8'(2 * j);
      v = mem[rb + 8'(4 + j)];
      for (int i = 0; i < 4; i++) begin
        w = mem[rb + 8'(i)];
        e.data[32*i +: 32] = 32'(v[16*i +: 16]) * 32'(w[16*i +: 16]);
      end
      sb_q.push_back(e);
    end
  endtask

  // Start is driven in relative cycle 0; returns at relative cycle 1.
  task automatic start_job(input logic [7:0] rb, input logic [7:0] wb, input logic [7:0] nv, input logic sm);
    @(posedge clk); #1;
    rbase_addr = rb; wbase_addr = wb; nvec = nv; simd_mode = sm; start = 1'b1;
    t0 = cyc;
    rd_addr_q.delete(); rd_rel_q.delete(); wr_rel_q.delete();
    wr_cnt = 0; done_cnt = 0; done_rel = -1; pe_rst_lo = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(posedge clk); #1; n++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL done_timeout: got no done in %0d cycles, required done", budget); end
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_rd_en, mem_wr_en, busy, done, pe_rst_n, pe_simd} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 000000", {mem_rd_en, mem_wr_en, busy, done, pe_rst_n, pe_simd});
    end
    checks++;
    if (status !== 32'h0 || mem_addr !== 8'h0 || mem_wdata !== '0 || pe_vector !== '0 || pe_load_ctrl !== '0) begin
      errors++; $display("FAIL reset_data: got status %h addr %h, required all zero", status, mem_addr);
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (pe_rst_n !== 1'b1 || status !== 32'h0) begin
      errors++; $display("FAIL reset_release: got pe_rst_n %b status %h, required 1 and 0", pe_rst_n, status);
    end
  endtask

  task automatic test_basic();
    fill_job(8'h10, 3, 1'b1);
    push_job(8'h10, 8'h80, 3);
    start_job(8'h10, 8'h80, 8'd3, 1'b0);
    checks++;
    if (status !== 32'h21) begin errors++; $display("FAIL basic_status_getw: got %h, required 21", status); end
    wait_done(40);
    checks++;
    if (rd_addr_q.size() != 7) begin errors++; $display("FAIL basic_rd_count: got %0d, required 7", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < 7; i++) begin
      checks++;
      if (rd_addr_q[i] !== 8'(8'h10 + i) || rd_rel_q[i] != i + 1) begin
        errors++; $display("FAIL basic_rd_%0d: got addr %h cycle %0d, required addr %h cycle %0d",
                           i, rd_addr_q[i], rd_rel_q[i], 8'(8'h10 + i), i + 1);
      end
    end
    checks++;
    if (wr_rel_q.size() != 3) begin errors++; $display("FAIL basic_wr_count: got %0d, required 3", wr_rel_q.size()); end
    for (int i = 0; i < wr_rel_q.size() && i < 3; i++) begin
      checks++;
      if (wr_rel_q[i] != 13 + i) begin errors++; $display("FAIL basic_wr_cycle_%0d: got %0d, required %0d", i, wr_rel_q[i], 13 + i); end
    end
    checks++;
    if (done_cnt != 1 || done_rel != 16) begin
      errors++; $display("FAIL basic_done: got count %0d cycle %0d, required 1 at 16", done_cnt, done_rel);
    end
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_end: got pending %0d busy %b, required 0 and 0", sb_q.size(), busy);
    end
  endtask

  task automatic test_zero_nvec();
    @(posedge clk); #1;
    t0 = cyc; rd_addr_q.delete(); wr_cnt = 0;
    nvec = 8'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    checks++;
    if (status !== 32'h80) begin errors++; $display("FAIL zero_status: got %h, required 80", status); end
    checks++;
    if (rd_addr_q.size() != 0 || wr_cnt != 0) begin
      errors++; $display("FAIL zero_strobes: got reads %0d writes %0d, required 0 0", rd_addr_q.size(), wr_cnt);
    end
    fill_job(8'h40, 2, 1'b0);
    push_job(8'h40, 8'h90, 2);
    start_job(8'h40, 8'h90, 8'd2, 1'b0);
    checks++;
    if (status !== 32'h21) begin errors++; $display("FAIL zero_err_clear: got %h, required 21", status); end
    wait_done(40);
    checks++;
    if (wr_cnt != 2 || sb_q.size() != 0) begin errors++; $display("FAIL zero_job: got writes %0d pending %0d, required 2 0", wr_cnt, sb_q.size()); end
  endtask

  task automatic test_abort();
    fill_job(8'h20, 4, 1'b1);
    start_job(8'h20, 8'hA0, 8'd4, 1'b0);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || pe_rst_n !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_next: got busy %b pe_rst_n %b done %b, required 0 0 0", busy, pe_rst_n, done);
    end
    tick(1);
    checks++;
    if (pe_rst_n !== 1'b1) begin errors++; $display("FAIL abort_pe_rst_release: got %b, required 1", pe_rst_n); end
    tick(20);
    checks++;
    if (wr_cnt != 0 || done_cnt != 0 || pe_rst_lo != 1 || rd_addr_q.size() != 6) begin
      errors++; $display("FAIL abort_counts: got writes %0d done %0d pe_rst_low %0d reads %0d, required 0 0 1 6",
                         wr_cnt, done_cnt, pe_rst_lo, rd_addr_q.size());
    end
    checks++;
    if (status !== 32'h40) begin errors++; $display("FAIL abort_status: got %h, required 40", status); end
    // start and abort together in IDLE: abort wins
    nvec = 8'd3; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || status !== 32'h40) begin
      errors++; $display("FAIL abort_vs_start: got busy %b status %h, required 0 40", busy, status);
    end
    tick(2);
  endtask

  task automatic test_long();
    bit ok;
    fill_job(8'h30, 20, 1'b0);
    push_job(8'h30, 8'h40, 20);
    start_job(8'h30, 8'h40, 8'd20, 1'b1);
    checks++;
    if (pe_simd !== 1'b1 || status !== 32'h21) begin
      errors++; $display("FAIL long_start: got simd %b status %h, required 1 21", pe_simd, status);
    end
    wait_done(300);
    checks++;
    if (wr_cnt != 20 || done_cnt != 1 || sb_q.size() != 0) begin
      errors++; $display("FAIL long_counts: got writes %0d done %0d pending %0d, required 20 1 0", wr_cnt, done_cnt, sb_q.size());
    end
    ok = (rd_addr_q.size() == 24);
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] !== 8'(8'h30 + i)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL long_reads: got %0d reads (or out of order), required 24 at 30..47", rd_addr_q.size()); end
  endtask

  task automatic test_wrap();
    fill_job(8'hFE, 2, 1'b0);
    push_job(8'hFE, 8'hFE, 2);
    start_job(8'hFE, 8'hFE, 8'd2, 1'b0);
    tick(2);
    nvec = 8'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(60);
    checks++;
    if (rd_addr_q.size() < 3 || rd_addr_q[0] !== 8'hFE || rd_addr_q[1] !== 8'hFF || rd_addr_q[2] !== 8'h00) begin
      errors++; $display("FAIL wrap_reads: got %0d reads, required FE FF 00 first", rd_addr_q.size());
    end
    checks++;
    if (wr_cnt != 2 || done_cnt != 1 || sb_q.size() != 0 || rd_addr_q.size() != 6) begin
      errors++; $display("FAIL wrap_counts: got writes %0d done %0d pending %0d reads %0d, required 2 1 0 6",
                         wr_cnt, done_cnt, sb_q.size(), rd_addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    fill_job(8'h10, 3, 1'b1);
    push_job(8'h10, 8'h80, 3);
    start_job(8'h10, 8'h80, 8'd3, 1'b1);
    tick(9);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, mem_wr_en, busy, done, pe_rst_n, pe_simd} !== 6'b0 || status !== 32'h0 ||
        mem_addr !== 8'h0 || mem_wdata !== '0 || pe_vector !== '0 || pe_load_ctrl !== '0) begin
      errors++; $display("FAIL reset_mid: got ctrl %b status %h addr %h, required all zero",
                         {mem_rd_en, mem_wr_en, busy, done, pe_rst_n, pe_simd}, status, mem_addr);
    end
    sb_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    test_basic();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; simd_mode = 1'b0;
    rbase_addr = '0; wbase_addr = '0; nvec = '0;
    wr_cnt = 0; done_cnt = 0; done_rel = -1; pe_rst_lo = 0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    test_reset();
    test_basic();
    test_zero_nvec();
    test_abort();
    test_long();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
